// File: rtl/tmds_deser_1to10_align_pkg.sv
// tmds_deser_1to10_align_pkg: shared TMDS receive constants, lock-state enum and helpers.
package tmds_deser_1to10_align_pkg;
    localparam int TMDS_WORD_W = 10;
    localparam logic [TMDS_WORD_W-1:0] TMDS_CTRL_TOKEN0 = 10'h354;
    localparam logic [TMDS_WORD_W-1:0] TMDS_CTRL_TOKEN1 = 10'h0AB;
    localparam logic [TMDS_WORD_W-1:0] TMDS_CTRL_TOKEN2 = 10'h154;
    localparam logic [TMDS_WORD_W-1:0] TMDS_CTRL_TOKEN3 = 10'h2AB;

    typedef enum logic {SEARCH, LOCKED} lock_state_e;

    function automatic logic is_ctrl_token(input logic [TMDS_WORD_W-1:0] w);
        return (w == TMDS_CTRL_TOKEN0) || (w == TMDS_CTRL_TOKEN1) ||
               (w == TMDS_CTRL_TOKEN2) || (w == TMDS_CTRL_TOKEN3);
    endfunction

    function automatic logic [3:0] next_slip(input logic [3:0] s);
        return (s == 4'd9) ? 4'd0 : s + 4'd1;
    endfunction
endpackage

// File: rtl/tmds_deser_1to10_align_gearbox.sv
// tmds_word_gearbox: 2-bit-per-clock history and slip-indexed 10-bit word extraction,
// one word every 5 clocks.
module tmds_word_gearbox
    import tmds_deser_1to10_align_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   din_h_i,
    input  logic                   din_l_i,
    input  logic [3:0]             slip_i,
    output logic [TMDS_WORD_W-1:0] dout_o,
    output logic                   dout_valid_o
);
    logic [2*TMDS_WORD_W-1:0] hist_q, hist_d;
    logic [2:0]               phase_q, phase_d;
    logic [TMDS_WORD_W-1:0]   dout_q, dout_d;
    logic                     dout_valid_q, dout_valid_d;

    // hist[0] is the oldest bit, so a right shift by slip puts the word's first bit at [0].
    always_comb begin
        hist_d       = {din_l_i, din_h_i, hist_q[2*TMDS_WORD_W-1:2]};
        phase_d      = (phase_q == 3'd4) ? 3'd0 : phase_q + 3'd1;
        dout_d       = (phase_q == 3'd4) ? TMDS_WORD_W'(hist_q >> slip_i) : dout_q;
        dout_valid_d = (phase_q == 3'd4);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hist_q       <= '0;
            phase_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            hist_q       <= hist_d;
            phase_q      <= phase_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout_o       = dout_q;
    assign dout_valid_o = dout_valid_q;
endmodule

// File: rtl/tmds_deser_1to10_align.sv
// tmds_deser_1to10_align: TMDS lane deserializer with bit-slip word alignment on
// DVI control tokens and lock tracking.
module tmds_deser_1to10_align
    import tmds_deser_1to10_align_pkg::*;
#(
    parameter int TOKEN_RUN    = 8,
    parameter int SEARCH_WORDS = 16,
    parameter int LOSS_WORDS   = 16384
) (
    input  logic                   clkx5,
    input  logic                   rst_n,
    input  logic                   din_h,
    input  logic                   din_l,
    input  logic                   realign,
    output logic [TMDS_WORD_W-1:0] dout,
    output logic                   dout_valid,
    output logic                   locked,
    output logic                   token_det,
    output logic [3:0]             slip
);
    localparam int RUN_W  = $clog2(TOKEN_RUN) + 1;
    localparam int WORD_W = $clog2(SEARCH_WORDS) + 1;
    localparam int LOSS_W = $clog2(LOSS_WORDS) + 1;
    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(TOKEN_RUN - 1);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(SEARCH_WORDS - 1);
    localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_WORDS - 1);

    lock_state_e       state_q, state_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [LOSS_W-1:0] loss_q, loss_d;
    logic [3:0]        slip_q, slip_d;

    tmds_word_gearbox u_gearbox (
        .clk_i       (clkx5),
        .rst_ni      (rst_n),
        .din_h_i     (din_h),
        .din_l_i     (din_l),
        .slip_i      (slip_q),
        .dout_o      (dout),
        .dout_valid_o(dout_valid)
    );

    assign token_det = is_ctrl_token(dout);
    assign locked    = (state_q == LOCKED);
    assign slip      = slip_q;

    // realign wins over any lock/loss decision taken on the same strobe.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        word_d  = word_q;
        loss_d  = loss_q;
        slip_d  = slip_q;
        if (realign) begin
            state_d = SEARCH;
            run_d   = '0;
            word_d  = '0;
            loss_d  = '0;
            slip_d  = next_slip(slip_q);
        end else if (dout_valid && state_q == SEARCH) begin
            if (token_det) begin
                run_d   = (run_q == RUN_LAST) ? '0 : run_q + RUN_W'(1);
                state_d = (run_q == RUN_LAST) ? LOCKED : SEARCH;
            end else begin
                run_d  = '0;
                word_d = (word_q == WORD_LAST) ? '0 : word_q + WORD_W'(1);
                slip_d = (word_q == WORD_LAST) ? next_slip(slip_q) : slip_q;
            end
        end else if (dout_valid) begin
            if (token_det) begin
                loss_d = '0;
            end else if (loss_q == LOSS_LAST) begin
                state_d = SEARCH;
                run_d   = '0;
                word_d  = '0;
                loss_d  = '0;
            end else begin
                loss_d = loss_q + LOSS_W'(1);
            end
        end
    end

    always_ff @(posedge clkx5 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEARCH;
            run_q   <= '0;
            word_q  <= '0;
            loss_q  <= '0;
            slip_q  <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            word_q  <= word_d;
            loss_q  <= loss_d;
            slip_q  <= slip_d;
        end
    end
endmodule

// File: tb/tb_tmds_deser_1to10_align.sv
// tb_tmds_deser_1to10_align: directed bench for the TMDS lane deserializer/aligner,
// driving a word-level wire model through a DDR bit-pair driver.
module tb_tmds_deser_1to10_align;
    localparam int LW = 80;

    logic       clkx5 = 1'b0;
    logic       rst_n = 1'b0;
    logic       din_h = 1'b0;
    logic       din_l = 1'b0;
    logic       realign = 1'b0;
    logic [9:0] dout;
    logic       dout_valid;
    logic       locked;
    logic       token_det;
    logic [3:0] slip;

    int         checks = 0;
    int         failures = 0;
    int         disp = 0;
    bit         bq[$];
    logic [9:0] wq[$];
    logic [9:0] fill_word = 10'h354;

    tmds_deser_1to10_align #(.LOSS_WORDS(LW)) dut (
        .clkx5     (clkx5),
        .rst_n     (rst_n),
        .din_h     (din_h),
        .din_l     (din_l),
        .realign   (realign),
        .dout      (dout),
        .dout_valid(dout_valid),
        .locked    (locked),
        .token_det (token_det),
        .slip      (slip)
    );

    always #5 clkx5 = ~clkx5;

    // Wire model: words go out LSB first, two bits per clock, earlier bit on din_h.
    initial begin
        logic [9:0] w;
        forever begin
            @(negedge clkx5);
            #1;
            if (bq.size() < 2) begin
                w = (wq.size() > 0) ? wq.pop_front() : fill_word;
                for (int i = 0; i < 10; i++) bq.push_back(w[i]);
            end
            din_h = bq.pop_front();
            din_l = bq.pop_front();
        end
    end

    task automatic tick();
        @(posedge clkx5);
        #1;
    endtask

    task automatic wait_strobe();
        int n = 0;
        do begin
            tick();
            n++;
        end while (!dout_valid && n < 12);
        if (!dout_valid) begin
            checks++;
            failures++;
            $display("FAIL strobe_timeout dout_valid=%0b expected=1", dout_valid);
        end
    endtask

    task automatic wait_lock(output int n);
        n = 0;
        do begin
            wait_strobe();
            tick();
            n++;
        end while (!locked && n < 200);
    endtask

    task automatic do_reset(input int pre, input logic [9:0] fw);
        rst_n   = 1'b0;
        realign = 1'b0;
        repeat (3) @(negedge clkx5);
        bq.delete();
        wq.delete();
        fill_word = fw;
        disp = 0;
        for (int i = 0; i < pre; i++) bq.push_back(1'b0);
        rst_n = 1'b1;
    endtask

    task automatic pulse_at_strobe();
        wait_strobe();
        realign = 1'b1;
        tick();
        realign = 1'b0;
    endtask

    task automatic tmds_enc(input logic [7:0] d, output logic [9:0] q);
        logic [8:0] qm;
        logic       xnor_m;
        int         n1;
        int         n0;
        n1     = $countones(d);
        xnor_m = (n1 > 4) || (n1 == 4 && !d[0]);
        qm[0]  = d[0];
        for (int i = 1; i < 8; i++) qm[i] = xnor_m ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = ~xnor_m;
        n1 = $countones(qm[7:0]);
        n0 = 8 - n1;
        if (disp == 0 || n1 == n0) begin
            q = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            disp += qm[8] ? (n1 - n0) : (n0 - n1);
        end else if ((disp > 0 && n1 > n0) || (disp < 0 && n0 > n1)) begin
            q = {1'b1, qm[8], ~qm[7:0]};
            disp += 2 * int'(qm[8]) + (n0 - n1);
        end else begin
            q = {1'b0, qm[8], qm[7:0]};
            disp += -2 * int'(!qm[8]) + (n1 - n0);
        end
    endtask

    task automatic test_reset();
        do_reset(8, 10'h354);
        checks++;
        if ({dout, dout_valid, locked, token_det, slip} !== 17'h0) begin
            failures++;
            $display("FAIL reset_state dout=%h valid=%b locked=%b tok=%b slip=%0d expected all 0",
                     dout, dout_valid, locked, token_det, slip);
        end
    endtask

    task automatic test_lock_slip0();
        logic [9:0] exp;
        for (int s = 1; s <= 10; s++) begin
            wait_strobe();
            exp = (s <= 2) ? 10'h000 : 10'h354;
            checks++;
            if (dout !== exp) begin
                failures++;
                $display("FAIL lock0_dout strobe=%0d got=%h expected=%h", s, dout, exp);
            end
            checks++;
            if (token_det !== (s > 2)) begin
                failures++;
                $display("FAIL lock0_token_det strobe=%0d got=%b expected=%b", s, token_det, s > 2);
            end
            tick();
            checks++;
            if (locked !== (s == 10)) begin
                failures++;
                $display("FAIL lock0_locked strobe=%0d got=%b expected=%b", s, locked, s == 10);
            end
        end
        checks++;
        if (slip !== 4'd0) begin
            failures++;
            $display("FAIL lock0_slip got=%0d expected=0", slip);
        end
    endtask

    task automatic test_loss_hold();
        int nt = 0;
        bit drop = 1'b0;
        for (int i = 0; i < LW - 1; i++) wq.push_back(10'h1F0);
        for (int s = 0; s < LW + 20; s++) begin
            wait_strobe();
            if (!locked) drop = 1'b1;
            if (dout == 10'h1F0) nt++;
            else if (nt > 0) break;
        end
        tick();
        checks++;
        if (nt !== LW - 1) begin
            failures++;
            $display("FAIL hold_run got=%0d expected=%0d", nt, LW - 1);
        end
        checks++;
        if (drop || locked !== 1'b1) begin
            failures++;
            $display("FAIL hold_locked dropped=%b locked=%b expected locked=1 throughout", drop, locked);
        end
    endtask

    task automatic test_loss_drop();
        int nt = 0;
        int n;
        for (int i = 0; i < LW; i++) wq.push_back(10'h1F0);
        for (int s = 0; s < LW + 20 && nt < LW; s++) begin
            wait_strobe();
            if (dout == 10'h1F0) begin
                nt++;
                if (nt >= LW - 1) begin
                    tick();
                    checks++;
                    if (locked !== (nt == LW - 1)) begin
                        failures++;
                        $display("FAIL drop_locked nontoken=%0d got=%b expected=%b", nt, locked, nt == LW - 1);
                    end
                end
            end
        end
        checks++;
        if (nt !== LW || slip !== 4'd0) begin
            failures++;
            $display("FAIL drop_end nontoken=%0d slip=%0d expected %0d and 0", nt, slip, LW);
        end
        wait_lock(n);
        checks++;
        if (n !== 8 || locked !== 1'b1) begin
            failures++;
            $display("FAIL drop_relock strobes=%0d locked=%b expected 8 and 1", n, locked);
        end
    endtask

    task automatic test_realign();
        int n;
        pulse_at_strobe();
        checks++;
        if (locked !== 1'b0 || slip !== 4'd1) begin
            failures++;
            $display("FAIL realign_locked locked=%b slip=%0d expected 0 and 1", locked, slip);
        end
        repeat (8) pulse_at_strobe();
        checks++;
        if (slip !== 4'd9) begin
            failures++;
            $display("FAIL realign_to9 slip=%0d expected=9", slip);
        end
        pulse_at_strobe();
        checks++;
        if (slip !== 4'd0 || locked !== 1'b0) begin
            failures++;
            $display("FAIL realign_wrap slip=%0d locked=%b expected 0 and 0", slip, locked);
        end
        repeat (7) wait_strobe();
        pulse_at_strobe();
        checks++;
        if (locked !== 1'b0 || slip !== 4'd1) begin
            failures++;
            $display("FAIL realign_priority locked=%b slip=%0d expected 0 and 1", locked, slip);
        end
        repeat (9) pulse_at_strobe();
        wait_lock(n);
        checks++;
        if (n !== 8 || slip !== 4'd0) begin
            failures++;
            $display("FAIL realign_relock strobes=%0d slip=%0d expected 8 and 0", n, slip);
        end
    endtask

    task automatic test_slip_search(input int d);
        int n;
        do_reset(8 + d, 10'h2AB);
        wait_lock(n);
        checks++;
        if (n !== 16 * d + 8 || slip !== 4'(d)) begin
            failures++;
            $display("FAIL search_d%0d strobes=%0d slip=%0d expected %0d and %0d", d, n, slip, 16 * d + 8, d);
        end
        repeat (3) begin
            wait_strobe();
            checks++;
            if (dout !== 10'h2AB || slip !== 4'(d) || locked !== 1'b1) begin
                failures++;
                $display("FAIL search_d%0d_stable dout=%h slip=%0d locked=%b expected 2ab %0d 1",
                         d, dout, slip, locked, d);
            end
        end
    endtask

    task automatic test_reset_midstream();
        int first = 0;
        wait_strobe();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dout, dout_valid, locked, slip} !== 16'h0) begin
            failures++;
            $display("FAIL async_reset dout=%h valid=%b locked=%b slip=%0d expected all 0",
                     dout, dout_valid, locked, slip);
        end
        do_reset(8, 10'h354);
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (dout_valid && first == 0) first = i;
        end
        checks++;
        if (first !== 5) begin
            failures++;
            $display("FAIL reset_first_valid cycle=%0d expected=5", first);
        end
    endtask

    task automatic test_loopback();
        logic [9:0] exp[$];
        logic [9:0] q;
        int         n;
        int         s = 0;
        do_reset(12, 10'h0AB);
        wait_lock(n);
        checks++;
        if (n !== 72 || slip !== 4'd4) begin
            failures++;
            $display("FAIL loop_lock strobes=%0d slip=%0d expected 72 and 4", n, slip);
        end
        for (int i = 0; i < 64; i++) begin
            tmds_enc(8'($urandom_range(0, 255)), q);
            exp.push_back(q);
            wq.push_back(q);
        end
        do begin
            wait_strobe();
            s++;
        end while (dout == 10'h0AB && s < 20);
        for (int i = 0; i < 64; i++) begin
            if (i > 0) wait_strobe();
            checks++;
            if (dout !== exp[i]) begin
                failures++;
                $display("FAIL loop_word idx=%0d got=%h expected=%h", i, dout, exp[i]);
            end
        end
        checks++;
        if (locked !== 1'b1 || slip !== 4'd4) begin
            failures++;
            $display("FAIL loop_end locked=%b slip=%0d expected 1 and 4", locked, slip);
        end
    endtask

    initial begin
        test_reset();
        test_lock_slip0();
        test_loss_hold();
        test_loss_drop();
        test_realign();
        test_slip_search(3);
        test_slip_search(5);
        test_slip_search(7);
        test_reset_midstream();
        test_loopback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
